adc_emu_spi_slave: RTL

ADC_EMU_SPI_SLAVE -- requirements
Module: adc_emu_spi_slave

---
 rtl/adc_emu_spi_slave_if.sv | 38 +++
 rtl/adc_emu_spi_slave.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_emu_spi_slave_if.sv
// ----------------------------------------------------------------------------
// adc_emu_spi_slave_if
//   Bundles the SPI pins and the frame status outputs of the ADC emulator.
//
//   Signals
//     nCS         master -> slave  chip select, active-low
//     SCLK        master -> slave  SPI clock, idles high
//     DIN         master -> slave  command data, captured on SCLK rising edges
//     DOUT        slave  -> master serial conversion data, MSB first
//     DOUT_OE     slave  -> master DOUT drive enable (0 = high-impedance)
//     FRAME_DONE  slave  -> master one-CLK pulse on a valid frame
//     FRAME_ABORT slave  -> master one-CLK pulse on a short frame
//     ACTIVE_CH   slave  -> master channel of the current or last frame
//
//   CH_BITS must match the CH_BITS derived inside the slave from NUM_CH.
// ----------------------------------------------------------------------------
interface adc_emu_spi_slave_if #(
    parameter int CH_BITS = 2
);
    logic               nCS;
    logic               SCLK;
    logic               DIN;
    logic               DOUT;
    logic               DOUT_OE;
    logic               FRAME_DONE;
    logic               FRAME_ABORT;
    logic [CH_BITS-1:0] ACTIVE_CH;

    modport master (
        output nCS, SCLK, DIN,
        input  DOUT, DOUT_OE, FRAME_DONE, FRAME_ABORT, ACTIVE_CH
    );

    modport slave (
        input  nCS, SCLK, DIN,
        output DOUT, DOUT_OE, FRAME_DONE, FRAME_ABORT, ACTIVE_CH
    );
endinterface

// File: rtl/adc_emu_spi_slave.sv
// ----------------------------------------------------------------------------
// adc_emu_spi_slave
//   Emulates a multi-channel SPI ADC. Each channel owns a free-running
//   counter that stands in for a conversion result. A frame starts on an
//   nCS falling edge, shifts the latched sample out MSB-first on DOUT
//   (one leading zero, DATA_BITS of data, zero padding, last bit tri-stated),
//   and captures a channel number on DIN for the following frame. A frame
//   with enough SCLK falling edges advances the converted channel's counter;
//   a short frame is aborted without side effects.
//
//   Ports
//     CLK   system clock, at least 4x SCLK; all logic on its rising edge
//     nRST  synchronous active-low reset
//     bus   adc_emu_spi_slave_if.slave (SPI pins, DOUT/DOUT_OE, status)
// ----------------------------------------------------------------------------
module adc_emu_spi_slave #(
    parameter int DATA_BITS  = 12,
    parameter int FRAME_BITS = 16,
    parameter int NUM_CH     = 4,
    parameter int INCREMENT  = 1,
    parameter int CH_OFFSET  = 256,
    parameter int MIN_FALLS  = 10
) (
    input  logic               CLK,
    input  logic               nRST,
    adc_emu_spi_slave_if.slave bus
);

    localparam int CH_BITS    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int IDX_BITS   = $clog2(FRAME_BITS);
    localparam int MAX_CODE   = (1 << DATA_BITS) - 1;
    localparam int WRAP_LIMIT = MAX_CODE - INCREMENT;

    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(FRAME_BITS - 1);
    localparam logic [4:0]          EDGE_SAT = 5'd31;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACTIVE    = 2'd1,
        WAIT_HIGH = 2'd2
    } state_t;

    state_t state, state_next;

    // ------------------------------------------------------------------
    // Pin synchronisers and edge detectors. nCS/SCLK rest at 1 so a
    // reset release with the pins idle produces no edge.
    // ------------------------------------------------------------------
    logic ncs_s1, ncs_s2, ncs_q;
    logic sclk_s1, sclk_s2, sclk_q;
    logic din_s1, din_s2;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source, independent of block order.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            ncs_s1  <= 1'b1;
            ncs_s2  <= 1'b1;
            ncs_q   <= 1'b1;
            sclk_s1 <= 1'b1;
            sclk_s2 <= 1'b1;
            sclk_q  <= 1'b1;
            din_s1  <= 1'b0;
            din_s2  <= 1'b0;
        end else begin
            ncs_s1  <= bus.nCS;
            ncs_s2  <= ncs_s1;
            ncs_q   <= ncs_s2;
            sclk_s1 <= bus.SCLK;
            sclk_s2 <= sclk_s1;
            sclk_q  <= sclk_s2;
            din_s1  <= bus.DIN;
            din_s2  <= din_s1;
        end
    end

    logic ncs_fall, ncs_rise, sclk_fall, sclk_rise;
    assign ncs_fall  =  ncs_q  & ~ncs_s2;
    assign ncs_rise  = ~ncs_q  &  ncs_s2;
    assign sclk_fall =  sclk_q & ~sclk_s2;
    assign sclk_rise = ~sclk_q &  sclk_s2;

    // The synchroniser holds 1 through reset, so its output only reflects
    // the real nCS pin two edges after release. Until then the FSM waits in
    // WAIT_HIGH; this also hides the artificial falling edge seen when nCS
    // was held low across reset.
    logic [1:0] settle_cnt;
    logic       settled;

    always_ff @(posedge CLK) begin
        if (!nRST)
            settle_cnt <= 2'd0;
        else if (settle_cnt != 2'd2)
            settle_cnt <= settle_cnt + 2'd1;
    end

    assign settled = (settle_cnt == 2'd2);

    // ------------------------------------------------------------------
    // Frame state
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] counters [NUM_CH];
    logic [DATA_BITS-1:0] sample;
    logic [CH_BITS-1:0]   next_ch;
    logic [CH_BITS-1:0]   active_ch;
    logic [CH_BITS-1:0]   cmd_ch;
    logic [IDX_BITS-1:0]  bit_idx;
    logic [4:0]           falls;
    logic [4:0]           rises;
    logic                 frame_done;
    logic                 frame_abort;

    // FSM control strobes
    logic start_frame, frame_ok, frame_bad, fall_evt, rise_evt;

    always_ff @(posedge CLK) begin
        if (!nRST)
            state <= WAIT_HIGH;
        else
            state <= state_next;
    end

    // NOTE: every output of this block gets a default before the case so
    // no path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        frame_ok    = 1'b0;
        frame_bad   = 1'b0;
        fall_evt    = 1'b0;
        rise_evt    = 1'b0;

        case (state)
            WAIT_HIGH: begin
                if (ncs_rise || (settled && ncs_s2))
                    state_next = IDLE;
            end
            IDLE: begin
                if (ncs_fall) begin
                    state_next  = ACTIVE;
                    start_frame = 1'b1;
                end
            end
            ACTIVE: begin
                // nCS release wins over any SCLK edge on the same cycle.
                if (ncs_rise) begin
                    state_next = IDLE;
                    if (32'(falls) >= MIN_FALLS)
                        frame_ok = 1'b1;
                    else
                        frame_bad = 1'b1;
                end else begin
                    fall_evt = sclk_fall;
                    rise_evt = sclk_rise;
                end
            end
            default: state_next = WAIT_HIGH;
        endcase
    end

    // NOTE: the channel counters are reset like ordinary flops because each
    // channel must come out of reset with its own offset value.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int n = 0; n < NUM_CH; n++)
                counters[n] <= DATA_BITS'(n * CH_OFFSET);
            sample      <= '0;
            next_ch     <= '0;
            active_ch   <= '0;
            cmd_ch      <= '0;
            bit_idx     <= '0;
            falls       <= '0;
            rises       <= '0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            frame_done  <= frame_ok;
            frame_abort <= frame_bad;

            if (start_frame) begin
                sample    <= counters[next_ch];
                active_ch <= next_ch;
                bit_idx   <= '0;
                falls     <= '0;
                rises     <= '0;
            end

            if (fall_evt) begin
                if (falls != EDGE_SAT)
                    falls <= falls + 5'd1;
                if (bit_idx != LAST_IDX)
                    bit_idx <= bit_idx + IDX_BITS'(1);
            end

            if (rise_evt) begin
                if (rises != EDGE_SAT)
                    rises <= rises + 5'd1;
                // rises still holds the pre-edge count: rising edges
                // 2..CH_BITS+1 carry the channel number, MSB first.
                if (rises >= 5'd1 && 32'(rises) <= CH_BITS)
                    cmd_ch <= CH_BITS'({cmd_ch, din_s2});
            end

            if (frame_ok) begin
                if (32'(counters[active_ch]) <= WRAP_LIMIT)
                    counters[active_ch] <= counters[active_ch] + DATA_BITS'(INCREMENT);
                else
                    counters[active_ch] <= '0;

                if (32'(rises) >= CH_BITS + 1 && 32'(cmd_ch) < NUM_CH)
                    next_ch <= cmd_ch;
            end
        end
    end

    // ------------------------------------------------------------------
    // Serial output: bit_idx 0 is a leading zero, 1..DATA_BITS carry the
    // sample MSB first, the rest pad with zero, the final slot tri-states.
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] shifted;
    logic                 dout;
    logic                 dout_oe;

    always_comb begin
        shifted = sample << (bit_idx - IDX_BITS'(1));
        dout    = 1'b0;
        dout_oe = 1'b0;
        if (state == ACTIVE && bit_idx != LAST_IDX) begin
            dout_oe = 1'b1;
            if (bit_idx != '0 && 32'(bit_idx) <= DATA_BITS)
                dout = shifted[DATA_BITS-1];
        end
    end

    assign bus.DOUT        = dout;
    assign bus.DOUT_OE     = dout_oe;
    assign bus.FRAME_DONE  = frame_done;
    assign bus.FRAME_ABORT = frame_abort;
    assign bus.ACTIVE_CH   = active_ch;

endmodule
